// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs for EX and LS results, round-robin grant,
// one registered broadcast per cycle, issue stalls and mispredict flush.
module cdb_arbiter #(
    parameter int unsigned NICK_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              ex_en,
    input  logic [NICK_W-1:0] ex_nick,
    input  logic [DATA_W-1:0] ex_dt,
    input  logic              ex_ac,
    input  logic [ADDR_W-1:0] ex_j_pc,
    input  logic              ls_en,
    input  logic [NICK_W-1:0] ls_nick,
    input  logic [DATA_W-1:0] ls_dt,
    output logic              cdb_en,
    output logic [NICK_W-1:0] cdb_nick,
    output logic [DATA_W-1:0] cdb_dt,
    output logic              cdb_ac,
    output logic [ADDR_W-1:0] cdb_j_pc,
    output logic              cdb_src,
    output logic              ex_stall,
    output logic              ls_stall
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned EX_W  = NICK_W + DATA_W + 1 + ADDR_W;
    localparam int unsigned LS_W  = NICK_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

    logic [EX_W-1:0]   r_ex_mem [DEPTH];
    logic [LS_W-1:0]   r_ls_mem [DEPTH];
    logic [PTR_W-1:0]  r_ex_rd, r_ex_wr, r_ls_rd, r_ls_wr;
    logic [CNT_W-1:0]  r_ex_cnt, r_ls_cnt;
    logic              r_last_grant;
    logic              r_cdb_en, r_cdb_ac, r_cdb_src;
    logic [NICK_W-1:0] r_cdb_nick;
    logic [DATA_W-1:0] r_cdb_dt;
    logic [ADDR_W-1:0] r_cdb_j_pc;

    logic [PTR_W-1:0]  w_ex_rd_nxt, w_ex_wr_nxt, w_ls_rd_nxt, w_ls_wr_nxt;
    logic [CNT_W-1:0]  w_ex_cnt_nxt, w_ls_cnt_nxt;
    logic              w_last_grant_nxt;
    logic              w_cdb_en_nxt, w_cdb_ac_nxt, w_cdb_src_nxt;
    logic [NICK_W-1:0] w_cdb_nick_nxt;
    logic [DATA_W-1:0] w_cdb_dt_nxt;
    logic [ADDR_W-1:0] w_cdb_j_pc_nxt;

    logic [EX_W-1:0]   w_ex_in, w_ex_item;
    logic [LS_W-1:0]   w_ls_in, w_ls_item;
    logic [NICK_W-1:0] w_ex_item_nick, w_ls_item_nick;
    logic [DATA_W-1:0] w_ex_item_dt, w_ls_item_dt;
    logic              w_ex_item_ac;
    logic [ADDR_W-1:0] w_ex_item_j_pc;
    logic              w_ex_empty, w_ls_empty, w_ex_cand, w_ls_cand, w_ex_win, w_ls_win;
    logic              w_ex_pop, w_ls_pop, w_ex_push_req, w_ls_push_req, w_ex_push, w_ls_push;
    logic              w_active;

    assign w_active   = rdy && !flush;
    assign w_ex_in    = {ex_nick, ex_dt, ex_ac, ex_j_pc};
    assign w_ls_in    = {ls_nick, ls_dt};
    assign w_ex_empty = (r_ex_cnt == '0);
    assign w_ls_empty = (r_ls_cnt == '0);
    assign w_ex_cand  = !w_ex_empty || ex_en;
    assign w_ls_cand  = !w_ls_empty || ls_en;
    // An empty FIFO lets the incoming result bypass straight to the bus.
    assign w_ex_item  = w_ex_empty ? w_ex_in : r_ex_mem[r_ex_rd];
    assign w_ls_item  = w_ls_empty ? w_ls_in : r_ls_mem[r_ls_rd];
    assign {w_ex_item_nick, w_ex_item_dt, w_ex_item_ac, w_ex_item_j_pc} = w_ex_item;
    assign {w_ls_item_nick, w_ls_item_dt} = w_ls_item;

    assign w_ex_win = w_ex_cand && (!w_ls_cand || r_last_grant);
    assign w_ls_win = w_ls_cand && !w_ex_win;

    assign w_ex_pop      = w_ex_win && !w_ex_empty;
    assign w_ls_pop      = w_ls_win && !w_ls_empty;
    assign w_ex_push_req = ex_en && !(w_ex_win && w_ex_empty);
    assign w_ls_push_req = ls_en && !(w_ls_win && w_ls_empty);
    // A same-cycle pop frees the slot the write pointer is aiming at.
    assign w_ex_push     = w_ex_push_req && ((r_ex_cnt != FULL_CNT) || w_ex_pop);
    assign w_ls_push     = w_ls_push_req && ((r_ls_cnt != FULL_CNT) || w_ls_pop);

    always_comb begin
        w_ex_rd_nxt      = r_ex_rd;
        w_ex_wr_nxt      = r_ex_wr;
        w_ex_cnt_nxt     = r_ex_cnt;
        w_ls_rd_nxt      = r_ls_rd;
        w_ls_wr_nxt      = r_ls_wr;
        w_ls_cnt_nxt     = r_ls_cnt;
        w_last_grant_nxt = r_last_grant;
        w_cdb_en_nxt     = r_cdb_en;
        w_cdb_nick_nxt   = r_cdb_nick;
        w_cdb_dt_nxt     = r_cdb_dt;
        w_cdb_ac_nxt     = r_cdb_ac;
        w_cdb_j_pc_nxt   = r_cdb_j_pc;
        w_cdb_src_nxt    = r_cdb_src;
        if (rdy) begin
            w_cdb_en_nxt   = 1'b0;
            w_cdb_nick_nxt = '0;
            w_cdb_dt_nxt   = '0;
            w_cdb_ac_nxt   = 1'b0;
            w_cdb_j_pc_nxt = '0;
            w_cdb_src_nxt  = 1'b0;
            if (flush) begin
                w_ex_rd_nxt  = '0;
                w_ex_wr_nxt  = '0;
                w_ex_cnt_nxt = '0;
                w_ls_rd_nxt  = '0;
                w_ls_wr_nxt  = '0;
                w_ls_cnt_nxt = '0;
            end else begin
                if (w_ex_pop)  w_ex_rd_nxt = r_ex_rd + 1'b1;
                if (w_ex_push) w_ex_wr_nxt = r_ex_wr + 1'b1;
                if (w_ls_pop)  w_ls_rd_nxt = r_ls_rd + 1'b1;
                if (w_ls_push) w_ls_wr_nxt = r_ls_wr + 1'b1;
                w_ex_cnt_nxt = r_ex_cnt + CNT_W'(w_ex_push) - CNT_W'(w_ex_pop);
                w_ls_cnt_nxt = r_ls_cnt + CNT_W'(w_ls_push) - CNT_W'(w_ls_pop);
                if (w_ex_win) begin
                    w_cdb_en_nxt     = 1'b1;
                    w_cdb_nick_nxt   = w_ex_item_nick;
                    w_cdb_dt_nxt     = w_ex_item_dt;
                    w_cdb_ac_nxt     = w_ex_item_ac;
                    w_cdb_j_pc_nxt   = w_ex_item_j_pc;
                    w_last_grant_nxt = 1'b0;
                end else if (w_ls_win) begin
                    w_cdb_en_nxt     = 1'b1;
                    w_cdb_nick_nxt   = w_ls_item_nick;
                    w_cdb_dt_nxt     = w_ls_item_dt;
                    w_cdb_src_nxt    = 1'b1;
                    w_last_grant_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd      <= '0;
            r_ex_wr      <= '0;
            r_ex_cnt     <= '0;
            r_ls_rd      <= '0;
            r_ls_wr      <= '0;
            r_ls_cnt     <= '0;
            r_last_grant <= 1'b1;
            r_cdb_en     <= 1'b0;
            r_cdb_nick   <= '0;
            r_cdb_dt     <= '0;
            r_cdb_ac     <= 1'b0;
            r_cdb_j_pc   <= '0;
            r_cdb_src    <= 1'b0;
        end else begin
            r_ex_rd      <= w_ex_rd_nxt;
            r_ex_wr      <= w_ex_wr_nxt;
            r_ex_cnt     <= w_ex_cnt_nxt;
            r_ls_rd      <= w_ls_rd_nxt;
            r_ls_wr      <= w_ls_wr_nxt;
            r_ls_cnt     <= w_ls_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cdb_en     <= w_cdb_en_nxt;
            r_cdb_nick   <= w_cdb_nick_nxt;
            r_cdb_dt     <= w_cdb_dt_nxt;
            r_cdb_ac     <= w_cdb_ac_nxt;
            r_cdb_j_pc   <= w_cdb_j_pc_nxt;
            r_cdb_src    <= w_cdb_src_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_active && w_ex_push) r_ex_mem[r_ex_wr] <= w_ex_in;
        if (!rst && w_active && w_ls_push) r_ls_mem[r_ls_wr] <= w_ls_in;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_active) begin
            assert (!(w_ex_push_req && !w_ex_push)) else $error("cdb_arbiter: EX FIFO overflow");
            assert (!(w_ls_push_req && !w_ls_push)) else $error("cdb_arbiter: LS FIFO overflow");
        end
    end

    assign cdb_en   = r_cdb_en;
    assign cdb_nick = r_cdb_nick;
    assign cdb_dt   = r_cdb_dt;
    assign cdb_ac   = r_cdb_ac;
    assign cdb_j_pc = r_cdb_j_pc;
    assign cdb_src  = r_cdb_src;
    assign ex_stall = (r_ex_cnt >= STALL_CNT);
    assign ls_stall = (r_ls_cnt >= STALL_CNT);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-written corner sequences and
// random traffic against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int NICK_W = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst, rdy, flush, ex_en, ex_ac, ls_en;
    logic [NICK_W-1:0] ex_nick, ls_nick;
    logic [DATA_W-1:0] ex_dt, ls_dt;
    logic [ADDR_W-1:0] ex_j_pc;
    logic              cdb_en, cdb_ac, cdb_src, ex_stall, ls_stall;
    logic [NICK_W-1:0] cdb_nick;
    logic [DATA_W-1:0] cdb_dt;
    logic [ADDR_W-1:0] cdb_j_pc;

    always #5 clk = ~clk;

    cdb_arbiter #(.NICK_W(NICK_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ex_en(ex_en), .ex_nick(ex_nick), .ex_dt(ex_dt), .ex_ac(ex_ac), .ex_j_pc(ex_j_pc),
        .ls_en(ls_en), .ls_nick(ls_nick), .ls_dt(ls_dt),
        .cdb_en(cdb_en), .cdb_nick(cdb_nick), .cdb_dt(cdb_dt), .cdb_ac(cdb_ac),
        .cdb_j_pc(cdb_j_pc), .cdb_src(cdb_src), .ex_stall(ex_stall), .ls_stall(ls_stall)
    );

    typedef struct {
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
        logic              ac;
        logic [ADDR_W-1:0] jpc;
    } item_t;

    item_t m_exq[$];
    item_t m_lsq[$];
    logic  m_last, m_en, m_src;
    item_t m_out;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: push both arrivals, then the round-robin winner pops its queue head.
    task automatic model_edge();
        item_t it;
        bit    exc, lsc;
        if (rst) begin
            m_exq.delete(); m_lsq.delete();
            m_last = 1'b1; m_en = 1'b0; m_src = 1'b0; m_out = '{0, 0, 0, 0};
        end else if (rdy) begin
            m_en = 1'b0; m_src = 1'b0; m_out = '{0, 0, 0, 0};
            if (flush) begin
                m_exq.delete(); m_lsq.delete();
            end else begin
                if (ex_en) m_exq.push_back('{ex_nick, ex_dt, ex_ac, ex_j_pc});
                if (ls_en) m_lsq.push_back('{ls_nick, ls_dt, 1'b0, '0});
                exc = m_exq.size() != 0;
                lsc = m_lsq.size() != 0;
                if (exc && (!lsc || m_last)) begin
                    it = m_exq.pop_front(); m_en = 1'b1; m_out = it; m_last = 1'b0;
                end else if (lsc) begin
                    it = m_lsq.pop_front(); m_en = 1'b1; m_out = it; m_src = 1'b1;
                    m_last = 1'b1;
                end
                chk("ex_fifo_bound", 64'(m_exq.size() > DEPTH), 0);
                chk("ls_fifo_bound", 64'(m_lsq.size() > DEPTH), 0);
            end
        end
    endtask

    task automatic check_model();
        chk("cdb_en", cdb_en, m_en);
        chk("cdb_nick", cdb_nick, m_out.nick);
        chk("cdb_dt", cdb_dt, m_out.dt);
        chk("cdb_ac", cdb_ac, m_out.ac);
        chk("cdb_j_pc", cdb_j_pc, m_out.jpc);
        chk("cdb_src", cdb_src, m_src);
        chk("ex_stall", ex_stall, 64'(m_exq.size() >= DEPTH - 1));
        chk("ls_stall", ls_stall, 64'(m_lsq.size() >= DEPTH - 1));
    endtask

    task automatic step(input bit use_model);
        model_edge();
        @(posedge clk);
        #1;
        if (use_model) check_model();
    endtask

    task automatic drive(input int xe, input int xn, input int le, input int ln);
        ex_en = xe[0]; ex_nick = NICK_W'(xn); ex_dt = DATA_W'(32'h1000 + xn);
        ex_ac = xn[0]; ex_j_pc = ADDR_W'(32'h4000 + 4 * xn);
        ls_en = le[0]; ls_nick = NICK_W'(ln); ls_dt = DATA_W'(32'h2000 + ln);
    endtask

    task automatic ctl(input bit r, input bit y, input bit f);
        rst = r; rdy = y; flush = f;
    endtask

    typedef struct {
        logic              rst, rdy, flush, xe;
        logic [NICK_W-1:0] xn;
        logic [DATA_W-1:0] xd;
        logic              xa;
        logic [ADDR_W-1:0] xj;
        logic              le;
        logic [NICK_W-1:0] ln;
        logic [DATA_W-1:0] ld;
        logic              e_en;
        logic [NICK_W-1:0] e_nick;
        logic [DATA_W-1:0] e_dt;
        logic              e_ac;
        logic [ADDR_W-1:0] e_jpc;
        logic              e_src, e_xs, e_ls;
    } vec_t;

    function automatic vec_t mkv(int r, int y, int f, int xe, int xn, int xd, int xa, int xj,
                                 int le, int ln, int ld, int e, int en_, int ed, int ea,
                                 int ej, int es, int exs, int lss);
        vec_t v;
        v.rst = r[0]; v.rdy = y[0]; v.flush = f[0]; v.xe = xe[0];
        v.xn = NICK_W'(xn); v.xd = DATA_W'(xd); v.xa = xa[0]; v.xj = ADDR_W'(xj);
        v.le = le[0]; v.ln = NICK_W'(ln); v.ld = DATA_W'(ld);
        v.e_en = e[0]; v.e_nick = NICK_W'(en_); v.e_dt = DATA_W'(ed); v.e_ac = ea[0];
        v.e_jpc = ADDR_W'(ej); v.e_src = es[0]; v.e_xs = exs[0]; v.e_ls = lss[0];
        return v;
    endfunction

    vec_t vt[8];
    logic [NICK_W-1:0] obs_ex[$];
    logic [NICK_W-1:0] obs_ls[$];

    initial begin
        vt[0] = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0);
        vt[1] = mkv(0, 1, 0, 1, 3, 'h10, 0, 'h104, 0, 0, 0, 1, 3, 'h10, 0, 'h104, 0, 0, 0);
        vt[2] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0);
        vt[3] = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0);
        vt[4] = mkv(0, 1, 0, 1, 1, 'hA1, 1, 'h200, 1, 2, 'hB2, 1, 1, 'hA1, 1, 'h200, 0, 0, 0);
        vt[5] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 2, 'hB2, 0, 0, 1, 0, 0);
        vt[6] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0);
        vt[7] = mkv(0, 0, 0, 1, 5, 5, 1, 5, 1, 6, 6,      0, 0, 0, 0, 0, 0, 0, 0);

        ctl(1, 1, 0); drive(0, 0, 0, 0);
        step(0); step(0);

        // Directed table: single result, reset, simultaneous arrival, freeze when idle.
        for (int i = 0; i < 8; i++) begin
            rst = vt[i].rst; rdy = vt[i].rdy; flush = vt[i].flush;
            ex_en = vt[i].xe; ex_nick = vt[i].xn; ex_dt = vt[i].xd; ex_ac = vt[i].xa;
            ex_j_pc = vt[i].xj; ls_en = vt[i].le; ls_nick = vt[i].ln; ls_dt = vt[i].ld;
            step(0);
            chk($sformatf("v%0d_en", i), cdb_en, vt[i].e_en);
            chk($sformatf("v%0d_nick", i), cdb_nick, vt[i].e_nick);
            chk($sformatf("v%0d_dt", i), cdb_dt, vt[i].e_dt);
            chk($sformatf("v%0d_ac", i), cdb_ac, vt[i].e_ac);
            chk($sformatf("v%0d_jpc", i), cdb_j_pc, vt[i].e_jpc);
            chk($sformatf("v%0d_src", i), cdb_src, vt[i].e_src);
            chk($sformatf("v%0d_xs", i), ex_stall, vt[i].e_xs);
            chk($sformatf("v%0d_ls", i), ls_stall, vt[i].e_ls);
        end

        // Sustained contention with producers honouring stall; order per source kept.
        begin
            int  xi = 0, li = 0;
            bit  saw_xs = 0;
            ctl(1, 1, 0); drive(0, 0, 0, 0); step(1);
            ctl(0, 1, 0);
            for (int c = 0; c < 40; c++) begin
                drive(int'(xi < 6 && !ex_stall), xi, int'(li < 6 && !ls_stall), 8 + li);
                if (ex_en) xi++;
                if (ls_en) li++;
                step(1);
                if (ex_stall) saw_xs = 1;
                if (cdb_en && !cdb_src) obs_ex.push_back(cdb_nick);
                if (cdb_en && cdb_src) obs_ls.push_back(cdb_nick);
            end
            chk("t3_saw_ex_stall", saw_xs, 1);
            chk("t3_ex_count", obs_ex.size(), 6);
            chk("t3_ls_count", obs_ls.size(), 6);
            for (int k = 0; k < 6; k++) begin
                if (k < obs_ex.size()) chk($sformatf("t3_ex_order%0d", k), obs_ex[k], k);
                if (k < obs_ls.size()) chk($sformatf("t3_ls_order%0d", k), obs_ls[k], 8 + k);
            end
        end

        // Freeze with both FIFOs holding two entries, then resume draining.
        ctl(1, 1, 0); drive(0, 0, 0, 0); step(1);
        ctl(0, 1, 0);
        for (int c = 0; c < 4; c++) begin drive(1, c, 1, 8 + c); step(1); end
        ctl(0, 0, 0);
        for (int c = 0; c < 3; c++) begin drive(1, 12, 1, 13); step(1); end
        chk("t4_frozen_en", cdb_en, 1);
        ctl(0, 1, 0); drive(0, 0, 0, 0);
        for (int c = 0; c < 6; c++) step(1);

        // Flush with pending entries and a same-cycle arrival.
        for (int c = 0; c < 3; c++) begin drive(1, c, 1, 8 + c); step(1); end
        ctl(0, 1, 1); drive(1, 15, 1, 14); step(1);
        chk("t5_flush_en", cdb_en, 0);
        ctl(0, 1, 0); drive(0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin step(1); chk("t5_after_en", cdb_en, 0); end

        // Reset mid-drain with rdy low; EX must win the first contention afterwards.
        for (int c = 0; c < 3; c++) begin drive(1, c, 1, 8 + c); step(1); end
        ctl(1, 0, 0); drive(0, 0, 0, 0); step(1);
        chk("t6_rst_en", cdb_en, 0);
        ctl(0, 1, 0); drive(1, 7, 1, 9); step(1);
        chk("t6_first_src", cdb_src, 0);
        chk("t6_first_nick", cdb_nick, 7);
        drive(0, 0, 0, 0); step(1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            ctl(($urandom % 128) == 0, ($urandom % 8) != 0, ($urandom % 32) == 0);
            drive(int'(!ex_stall && ($urandom % 4 != 0)), int'($urandom % 16),
                  int'(!ls_stall && ($urandom % 3 != 0)), int'($urandom % 16));
            ex_dt = $urandom; ls_dt = $urandom; ex_j_pc = $urandom; ex_ac = 1'($urandom);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Single-port common data bus (CDB) arbiter between the execute (ALU) unit and the load/store buffer (SLB).
- Both producers emit at most one result per cycle. The CDB carries exactly one result per cycle to the RS, SLB and ROB.
- Per-source FIFOs absorb collisions. Round-robin grant resolves contention. Stall outputs throttle the RS and SLB issue stages.
- A branch-mispredict flush from the ROB discards all pending results.

Parameters:
NICK_W, 4, rename tag (nick) width
DATA_W, 32, result data width
ADDR_W, 32, jump-target width
DEPTH, 4, entries per source FIFO (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low = freeze
flush  in  1  ROB mispredict clear
ex_en  in  1  execute result valid
ex_nick  in  NICK_W  execute result tag
ex_dt  in  DATA_W  execute result data
ex_ac  in  1  branch taken (1 = Jump)
ex_j_pc  in  ADDR_W  resolved next pc
ls_en  in  1  load result valid
ls_nick  in  NICK_W  load result tag
ls_dt  in  DATA_W  load data
cdb_en  out  1  CDB broadcast valid
cdb_nick  out  NICK_W  broadcast tag
cdb_dt  out  DATA_W  broadcast data
cdb_ac  out  1  broadcast taken flag (0 for loads)
cdb_j_pc  out  ADDR_W  broadcast next pc (0 for loads)
cdb_src  out  1  0 = execute, 1 = load/store
ex_stall  out  1  RS must not issue to execute
ls_stall  out  1  SLB must not issue a load

Behaviour:
- Reset: all cdb_* outputs 0. Both FIFOs empty (pointers and counts 0). last_grant = 1 (LS), so EX wins the first contention.
- rdy low: no enqueue, no dequeue, no register change. Outputs hold. Inputs are ignored because producers also hold.
- Candidate for source S:
  - S FIFO non-empty → candidate item is the FIFO head.
  - S FIFO empty and S_en → candidate item is the incoming value (bypass).
- Grant:
  - One candidate → that source wins.
  - Two candidates → the source != last_grant wins.
  - last_grant updates to the winner on every grant.
- Output register: cdb_* is loaded with the winning item on the next edge, so CDB latency is 1 cycle from input with no contention.
  - No candidate → cdb_en = 0 and all other cdb_* fields are 0.
  - LS items are broadcast with cdb_ac = 0, cdb_j_pc = 0, cdb_src = 1.
- FIFO update per source in a cycle:
  - Winner with non-empty FIFO: pop head. Enqueue the incoming item if S_en. Count changes by 0 or −1.
  - Winner by bypass: no FIFO change.
  - Loser, or non-winner with S_en: enqueue incoming. Count +1.
  - Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
- Stall: ex_stall = (ex_count >= DEPTH−1); ls_stall = (ls_count >= DEPTH−1). Both are combinational from the count registers.
  - The threshold leaves one slot for the result already in flight when stall rises.
- Enqueue into a full FIFO is a protocol violation. The item is dropped and a simulation-only assertion fires. Count must never exceed DEPTH.
- flush (rdy high), on the next edge:
  - Both FIFOs emptied; cdb_en = 0 and all cdb_* fields = 0.
  - Same-cycle ex_en / ls_en inputs are discarded.
  - last_grant unchanged.
- flush has priority over all enqueue and grant activity. rst has priority over flush and rdy.
- Ordering: per-source FIFO order is preserved. No ordering is guaranteed between sources.

Test Plan:
1. Single EX result, ex_en=1, nick=3, dt=0x10, ac=0, j_pc=0x104 → next cycle cdb_en=1, nick=3, dt=0x10, j_pc=0x104, src=0; following cycle cdb_en=0, fields 0.
2. Simultaneous after reset, EX nick=1 and LS nick=2 in the same cycle → cycle+1 CDB nick=1 src=0; cycle+2 nick=2 src=1 (from LS FIFO); cycle+3 cdb_en=0.
3. Sustained contention, both sources valid every cycle for 6 cycles, stall honored → CDB alternates EX/LS; ex_stall rises when ex_count reaches 3 (DEPTH=4); no drop; all 12 tags appear in per-source order.
4. rdy low for 3 cycles while both FIFOs hold 2 entries and cdb_en=1 → outputs and counts frozen; on rdy high, draining resumes with the same alternation.
5. flush while FIFOs hold entries and ex_en=1 → next cycle cdb_en=0, counts 0, stalls low; the flushed-cycle input never appears on the CDB.
6. rst asserted mid-drain with rdy low → all outputs 0 and FIFOs empty next edge; first contention after reset is granted to EX.
